// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types, digit indices and per-digit limits for the MM:SS timer
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EDIT,
    COMMIT
  } state_t;

  localparam logic [1:0] DIG_M10 = 2'd3;
  localparam logic [1:0] DIG_M1  = 2'd2;
  localparam logic [1:0] DIG_S10 = 2'd1;
  localparam logic [1:0] DIG_S1  = 2'd0;

  localparam logic [3:0] LIM_M10 = 4'd9;
  localparam logic [3:0] LIM_M1  = 4'd9;
  localparam logic [3:0] LIM_S10 = 4'd5;
  localparam logic [3:0] LIM_S1  = 4'd9;

  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  function automatic logic [3:0] digit_limit(input logic [1:0] sel);
    case (sel)
      DIG_M10: digit_limit = LIM_M10;
      DIG_M1:  digit_limit = LIM_M1;
      DIG_S10: digit_limit = LIM_S10;
      default: digit_limit = LIM_S1;
    endcase
  endfunction

  // Anything at or above the limit (including loaded out-of-range values) wraps to 0.
  function automatic logic [3:0] inc_nibble(input logic [3:0] value, input logic [3:0] limit);
    inc_nibble = (value >= limit) ? 4'd0 : value + 4'd1;
  endfunction

endpackage

// File: rtl/timer_prog_ctrl_if.sv
// rtl/timer_prog_ctrl_if.sv - button, live-time and load/display signals of the programming controller
interface timer_prog_ctrl_if;
  logic        bt_next;
  logic        bt_inc;
  logic [15:0] cur_time;
  logic [15:0] disp_data;
  logic [15:0] load_value;
  logic        load_en;
  logic        prog_active;
  logic [1:0]  digit_sel;

  modport master (
    output bt_next, bt_inc, cur_time,
    input  disp_data, load_value, load_en, prog_active, digit_sel
  );

  modport slave (
    input  bt_next, bt_inc, cur_time,
    output disp_data, load_value, load_en, prog_active, digit_sel
  );
endinterface

// File: rtl/timer_prog_ctrl_edit_blink_gen.sv
// rtl/timer_prog_ctrl_edit_blink_gen.sv - blink phase divider with sync clear and enable
module edit_blink_gen #(
  parameter int CLK_FREQ = 25175000,
  parameter int BLINK_HZ = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic phase
);

  localparam int HALF = CLK_FREQ / (2 * BLINK_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_prog_ctrl.sv
// rtl/timer_prog_ctrl.sv - MM:SS programming-mode controller: digit edit, blink, timeout and commit strobe
module timer_prog_ctrl
  import timer_pkg::*;
#(
  parameter int CLK_FREQ  = 25175000,
  parameter int BLINK_HZ  = 2,
  parameter int TIMEOUT_S = 10
) (
  input logic              clk,
  input logic              rst,
  timer_prog_ctrl_if.slave bus
);

  localparam int TO_TERM = TIMEOUT_S * CLK_FREQ;
  localparam int TW      = (TO_TERM > 1) ? $clog2(TO_TERM) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TO_TERM - 1);

  state_t        state, state_nxt;
  logic [15:0]   edit_reg, edit_nxt, edit_inc;
  logic [1:0]    sel, sel_nxt;
  logic [TW-1:0] to_cnt;
  logic          commit_go;
  logic          blink;
  logic          pulse;

  assign pulse = bus.bt_next | bus.bt_inc;

  // Increment is applied before any advance so a simultaneous next commits the new value.
  always_comb begin
    edit_inc = edit_reg;
    if (bus.bt_inc)
      edit_inc[{sel, 2'b00} +: 4] = inc_nibble(edit_reg[{sel, 2'b00} +: 4], digit_limit(sel));
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    edit_nxt  = edit_reg;
    commit_go = 1'b0;
    case (state)
      IDLE: begin
        if (bus.bt_next) begin
          state_nxt = EDIT;
          edit_nxt  = bus.cur_time;
          sel_nxt   = DIG_M10;
        end
      end
      EDIT: begin
        edit_nxt = edit_inc;
        if (bus.bt_next) begin
          if (sel == DIG_S1) begin
            state_nxt = COMMIT;
            commit_go = 1'b1;
          end else begin
            sel_nxt = sel - 2'd1;
          end
        end else if (!bus.bt_inc && to_cnt == TO_LAST) begin
          state_nxt = IDLE;
        end
      end
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      edit_reg       <= 16'h0000;
      sel            <= DIG_M10;
      bus.load_en    <= 1'b0;
      bus.load_value <= 16'h0000;
      to_cnt         <= '0;
    end else begin
      state       <= state_nxt;
      edit_reg    <= edit_nxt;
      sel         <= sel_nxt;
      bus.load_en <= commit_go;
      if (commit_go)
        bus.load_value <= edit_inc;
      if (state_nxt != EDIT || pulse)
        to_cnt <= '0;
      else if (to_cnt != TO_LAST)
        to_cnt <= to_cnt + 1'b1;
    end
  end

  edit_blink_gen #(
    .CLK_FREQ(CLK_FREQ),
    .BLINK_HZ(BLINK_HZ)
  ) u_blink (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state_nxt != EDIT) || pulse),
    .en   (state == EDIT),
    .phase(blink)
  );

  assign bus.prog_active = (state == EDIT);
  assign bus.digit_sel   = sel;

  always_comb begin
    bus.disp_data = edit_reg;
    if (state == IDLE)
      bus.disp_data = bus.cur_time;
    else if (state == EDIT && blink)
      bus.disp_data[{sel, 2'b00} +: 4] = BLANK_NIBBLE;
  end

endmodule
